muldiv_ctrl: RTL
================

# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the execute stage. Accepts MULT/MULTU/DIV/DIVU from the 8-bit ALU control code, runs the operation over several cycles, stalls the pipeline while busy, and delivers a single HI/LO write pulse with the 64-bit result. Sits beside the ALU in E stage. Its outputs feed the HI/LO register write port and the hazard unit's stall input.

## Interface
- WIDTH, 32: operand width; HI/LO are WIDTH each.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alucontrol  in  8  E-stage ALU control code; only `EXE_MULT_OP`, `EXE_MULTU_OP`, `EXE_DIV_OP` and `EXE_DIVU_OP` are acted on.
- a  in  WIDTH  rs operand; multiplicand or dividend.
- b  in  WIDTH  rt operand; multiplier or divisor.
- flush  in  1  E-stage flush (exception or branch squash); aborts any operation.
- stall  out  1  hold IF..E stages; reset value 0.
- hilo_we  out  1  one-cycle HI/LO write strobe; reset value 0.
- hi  out  WIDTH  mult high word, or div remainder; reset value 0.
- lo  out  WIDTH  mult low word, or div quotient; reset value 0.

## Operation
- States: IDLE, MUL, DIV, DONE. State encoding uses localparams.
- **start** = (state==IDLE) & muldiv opcode on `alucontrol` & ~flush.
- **IDLE**
  - On start, latch operand magnitudes (absolute value for signed ops; raw value for unsigned ops).
  - Latch the result sign flags:
    - quotient/product negative when signed and a[31]^b[31];
    - remainder negative when signed and a[31].
  - Next state:
    - DIV/DIVU with b==0 → DONE, with lo=all-ones and hi=a.
    - Other DIV/DIVU → DIV, iteration counter cleared.
    - MULT/MULTU → MUL (iterative build) or DONE (fast build).
- **MUL**: shift-add, one multiplier bit per cycle, WIDTH cycles. When counter reaches WIDTH-1 → DONE.
- **DIV**: restoring radix-2, one quotient bit per cycle, WIDTH cycles. When counter reaches WIDTH-1 → DONE.
- **DONE**
  - Apply two's-complement sign fix and drive hi/lo.
  - hilo_we=1 for exactly this cycle.
  - Next state is IDLE unconditionally.
  - `alucontrol` is ignored here, because the same instruction is still in E.
- hi/lo hold their last value outside DONE. Consumers use them only when hilo_we=1.
- **flush**: in any state, next state is IDLE. hilo_we is forced 0 in the flush cycle, so a flush during DONE suppresses the write.
- **rst**: in any state, all registers and outputs are cleared next edge, including mid-operation.
- Signed −2^31 / −1: quotient 0x80000000, remainder 0; no trap.

## Timing
- stall = start | (state==MUL) | (state==DIV). It is combinational, so it asserts in the same cycle the instruction enters E.
- stall is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Cycle counts, start cycle = cycle 0:

| Case | stall high | hilo_we pulse |
|---|---|---|
| DIV/DIVU, iterative MUL/MULTU | cycles 0..WIDTH (WIDTH+1 cycles) | cycle WIDTH+1 |
| Divide-by-zero, fast multiply | cycle 0 only | cycle 1 |

- Back-to-back muldiv ops: the second op is in E in the cycle after DONE (state IDLE), so it starts immediately. No bubble is inserted by this block.
- flush and start in the same cycle: start is suppressed and stall=0.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - The multiply uses a single-cycle WIDTH×WIDTH `*` on magnitudes in the IDLE→DONE transition.
  - The MUL state is unreachable.
  - Multiply latency is 1 stall cycle.
- `MULDIV_FAST_MUL_EN` undefined:
  - The multiply uses the iterative shift-add, with the same timing as divide.
  - No hardware multiplier is inferred.
- Division is iterative in both builds.

## Structure
- ALU control codes (`EXE_MULT_OP`, `EXE_MULTU_OP`, `EXE_DIV_OP`, `EXE_DIVU_OP`) come from the shared defines header.
- Add `MULDIV_STATE_*` encodings and `MULDIV_ITERS` to the same header, for use by hazard-unit debug.
- Sub-module `muldiv_iter`: the 2·WIDTH-bit shift/accumulate datapath. It takes a mode (mul/div) and a step enable, and holds the partial result. The FSM, counter, sign handling and stall logic stay in `muldiv_ctrl`.

## Test plan
- **DIVU** a=100, b=7:
  - stall high 33 cycles;
  - hilo_we single pulse at cycle 33;
  - hi=2, lo=14.
- **DIV** a=0xFFFFFFF9 (−7), b=2: lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- **MULT** a=0xFFFFFFFF, b=2:
  - hi=0xFFFFFFFF, lo=0xFFFFFFFE;
  - same operands with MULTU give hi=0x00000001, lo=0xFFFFFFFE;
  - run in both `MULDIV_FAST_MUL_EN` builds and check stall length 1 vs 33.
- **DIVU** a=0x1234, b=0:
  - stall 1 cycle;
  - hilo_we at cycle 1;
  - lo=0xFFFFFFFF, hi=0x00001234.
- **Flush mid-DIV**:
  - DIVU 100/7 started, flush at cycle 10;
  - IDLE next cycle, stall 0, no hilo_we;
  - a following DIVU 9/3 then returns lo=3, hi=0 with normal timing.
- **Reset and back-to-back**:
  - rst at cycle 5 of a MULT (iterative build) clears stall, hilo_we, hi and lo next edge;
  - after release, back-to-back DIVU then MULTU gives two hilo_we pulses 34 cycles apart with no gap cycle.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared ALU control codes, mul/div state encodings and helpers
package muldiv_ctrl_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_ITERS = MULDIV_WIDTH;

    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [1:0] MULDIV_STATE_IDLE = 2'd0;
    localparam logic [1:0] MULDIV_STATE_MUL  = 2'd1;
    localparam logic [1:0] MULDIV_STATE_DIV  = 2'd2;
    localparam logic [1:0] MULDIV_STATE_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = MULDIV_STATE_IDLE,
        ST_MUL  = MULDIV_STATE_MUL,
        ST_DIV  = MULDIV_STATE_DIV,
        ST_DONE = MULDIV_STATE_DONE
    } muldiv_state_e;

    function automatic logic is_muldiv_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - 2*WIDTH-bit shift-add multiply / restoring divide datapath
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               mode_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               step,
    output logic [2*WIDTH-1:0] acc
);

    logic               div_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend bits / quotient bits}.
    always_comb begin
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        trial    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        acc_next = acc_q;
        if (div_q) begin
            if (trial[WIDTH])
                acc_next = {acc_q[2*WIDTH-2:0], 1'b0};
            else
                acc_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {add_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= 1'b0;
            opnd_q <= '0;
            acc_q  <= '0;
        end else if (load) begin
            div_q  <= mode_div;
            opnd_q <= mode_div ? opb : opa;
            acc_q  <= {{WIDTH{1'b0}}, (mode_div ? opa : opb)};
        end else if (step) begin
            acc_q  <= acc_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer with pipeline stall and HI/LO write
// MULDIV_FAST_MUL_EN: single-cycle multiply instead of iterative shift-add
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_e      state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic               is_op, op_div, op_signed, start, div_by_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               qneg_q, rneg_q, div_q, dz_q;
    logic [WIDTH-1:0]   araw_q;
    logic [WIDTH-1:0]   hi_hold_q, lo_hold_q;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               iter_load, iter_step, last_iter;
    logic [2*WIDTH-1:0] iter_acc;
    logic [2*WIDTH-1:0] prod_raw;
    logic [WIDTH-1:0]   quo, rem;

    assign is_op       = is_muldiv_op(alucontrol);
    assign op_div      = (alucontrol == EXE_DIV_OP) || (alucontrol == EXE_DIVU_OP);
    assign op_signed   = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_DIV_OP);
    assign start       = (state_q == ST_IDLE) && is_op && !flush;
    assign div_by_zero = op_div && (b == '0);
    assign mag_a       = (op_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b       = (op_signed && b[WIDTH-1]) ? -b : b;
    assign iter_step   = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign last_iter   = (cnt_q == CW'(WIDTH - 1));

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] prod_q;

    always_ff @(posedge clk) begin
        if (rst)
            prod_q <= '0;
        else if (start && !op_div)
            prod_q <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    end

    assign iter_load = start && op_div && !div_by_zero;
    assign prod_raw  = prod_q;
`else
    assign iter_load = start && !div_by_zero;
    assign prod_raw  = iter_acc;
`endif

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (iter_load),
        .mode_div (op_div),
        .opa      (mag_a),
        .opb      (mag_b),
        .step     (iter_step),
        .acc      (iter_acc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_div)
                        state_d = div_by_zero ? ST_DONE : ST_DIV;
                    else
`ifdef MULDIV_FAST_MUL_EN
                        state_d = ST_DONE;
`else
                        state_d = ST_MUL;
`endif
                end
            end
            ST_MUL:  if (last_iter) state_d = ST_DONE;
            ST_DIV:  if (last_iter) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush)
            state_d = ST_IDLE;
    end

    assign stall   = start || iter_step;
    assign hilo_we = (state_q == ST_DONE) && !flush;

    assign quo = iter_acc[WIDTH-1:0];
    assign rem = iter_acc[2*WIDTH-1:WIDTH];

    // Sign fix-up is applied to the unsigned magnitude result only in DONE.
    always_comb begin
        res_hi = hi_hold_q;
        res_lo = lo_hold_q;
        if (dz_q) begin
            res_hi = araw_q;
            res_lo = '1;
        end else if (div_q) begin
            res_lo = qneg_q ? -quo : quo;
            res_hi = rneg_q ? -rem : rem;
        end else begin
            {res_hi, res_lo} = qneg_q ? -prod_raw : prod_raw;
        end
    end

    assign hi = (state_q == ST_DONE) ? res_hi : hi_hold_q;
    assign lo = (state_q == ST_DONE) ? res_lo : lo_hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            div_q     <= 1'b0;
            dz_q      <= 1'b0;
            araw_q    <= '0;
            hi_hold_q <= '0;
            lo_hold_q <= '0;
        end else begin
            state_q <= state_d;
            if (start)
                cnt_q <= '0;
            else if (iter_step)
                cnt_q <= cnt_q + CW'(1);
            if (start) begin
                qneg_q <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_q <= op_signed && a[WIDTH-1];
                div_q  <= op_div;
                dz_q   <= div_by_zero;
                araw_q <= a;
            end
            if (hilo_we) begin
                hi_hold_q <= res_hi;
                lo_hold_q <= res_lo;
            end
        end
    end

endmodule
